// File: rtl/cipher_cfg_loader.sv
// Serial configuration-chain master for the stream cipher: shifts a parallel frame in LSB-first
// while capturing the previous chain contents. Optional read-only restore mode: CFG_LOADER_RESTORE_EN.
//
// state | meaning
// IDLE  | waiting for start (accepted once the post-done gap has expired)
// SHIFT | cfg_en high, one chain bit in/out per cycle for FRAME_W cycles
// DONE  | single-cycle done pulse, readback word valid
module cipher_cfg_loader #(
    parameter int M        = 32,
    parameter int IDLE_GAP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4*M+1:0]   frame_i,
    output logic             busy,
    output logic             done,
    output logic [4*M+1:0]   frame_o,
    output logic             cfg_en,
    output logic             cfg_i,
    input  logic             cfg_o
`ifdef CFG_LOADER_RESTORE_EN
    ,
    input  logic             rd_only
`endif
);

    localparam int FRAME_W = 4*M + 2;
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam int GAP_W   = $clog2(IDLE_GAP + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(IDLE_GAP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [FRAME_W-1:0]   sh_q, sh_d;
    logic [FRAME_W-1:0]   cap_q, cap_d;
    logic [FRAME_W-1:0]   frame_o_q, frame_o_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic                 cfg_en_q;
    logic                 gap_ok;
    logic                 rd_only_q, rd_only_d;

    // gap_q counts IDLE cycles since done; the current IDLE cycle itself counts toward the gap
    assign gap_ok = (int'(gap_q) >= (IDLE_GAP - 1));

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        cap_d     = cap_q;
        frame_o_d = frame_o_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        rd_only_d = rd_only_q;
        case (state_q)
            S_IDLE: begin
                if (gap_q != GAP_MAX) begin
                    gap_d = gap_q + GAP_W'(1);
                end
                if (start && gap_ok) begin
                    sh_d    = frame_i;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
`ifdef CFG_LOADER_RESTORE_EN
                    rd_only_d = rd_only;
`else
                    rd_only_d = 1'b0;
`endif
                end
            end
            S_SHIFT: begin
                sh_d  = sh_q >> 1;
                cap_d = {cfg_o, cap_q[FRAME_W-1:1]};
                if (cnt_q == CNT_LAST) begin
                    frame_o_d = {cfg_o, cap_q[FRAME_W-1:1]};
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                gap_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sh_q      <= '0;
            cap_q     <= '0;
            frame_o_q <= '0;
            cnt_q     <= '0;
            gap_q     <= GAP_MAX;
            cfg_en_q  <= 1'b0;
            rd_only_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            cap_q     <= cap_d;
            frame_o_q <= frame_o_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            cfg_en_q  <= (state_d == S_SHIFT);
            rd_only_q <= rd_only_d;
        end
    end

    // Recirculating cfg_o back into the chain leaves the cipher contents unchanged
    assign cfg_i   = cfg_en_q & (rd_only_q ? cfg_o : sh_q[0]);
    assign cfg_en  = cfg_en_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign frame_o = frame_o_q;

endmodule

// File: tb/tb_cipher_cfg_loader.sv
// Testbench for cipher_cfg_loader paired with a behavioural cipher chain model.
// Build with +define+CFG_LOADER_RESTORE_EN to also exercise read-only restore transfers.
module tb_cipher_cfg_loader;

    localparam int M  = 32;
    localparam int FW = 4*M + 2;
    localparam logic [FW-1:0] RESET_CHAIN =
        {2'b00, 32'h48000000, 32'h00000055, 32'h48000000, 32'h00000055};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [FW-1:0] frame_i;
    logic          busy;
    logic          done;
    logic [FW-1:0] frame_o;
    logic          cfg_en;
    logic          cfg_i;
    logic          cfg_o;
    logic          rd_only_v;

    logic [FW-1:0] chain;

    int checks = 0;
    int errors = 0;
    logic [FW-1:0] sb[$];

    typedef struct {
        logic [FW-1:0] frame;
        logic [FW-1:0] exp_o;
    } vec_t;
    vec_t vecs[4];

    cipher_cfg_loader #(.M(M), .IDLE_GAP(1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .frame_i (frame_i),
        .busy    (busy),
        .done    (done),
        .frame_o (frame_o),
        .cfg_en  (cfg_en),
        .cfg_i   (cfg_i),
        .cfg_o   (cfg_o)
`ifdef CFG_LOADER_RESTORE_EN
        ,
        .rd_only (rd_only_v)
`endif
    );

    always #5 clk = ~clk;

    // Cipher configuration chain: shifts toward bit 0 while cfg_en is high, shares the reset net
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain <= RESET_CHAIN;
        else if (cfg_en) chain <= {cfg_i, chain[FW-1:1]};
    end
    assign cfg_o = chain[0];

    task automatic check(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_frame(input logic [FW-1:0] f, input logic rd, input logic [FW-1:0] exp_o,
                             input int pulse_at);
        logic [FW-1:0] bits;
        logic [FW-1:0] exp_chain;
        int en_cnt, done_cnt, done_cyc, tail;
        bits      = '0;
        en_cnt    = 0;
        done_cnt  = 0;
        done_cyc  = 0;
        tail      = (pulse_at > 0) ? 5 : 0;
        exp_chain = rd ? exp_o : f;
        @(negedge clk);
        check("idle_busy", FW'(busy), FW'(1'b0));
        frame_i   = f;
        rd_only_v = rd;
        start     = 1'b1;
        sb.push_back(exp_o);
        @(posedge clk);
        #1;
        start   = 1'b0;
        frame_i = ~f;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (n == pulse_at) start = 1'b1;
            else if (n == pulse_at + 1) start = 1'b0;
            if (cfg_en) begin
                if (en_cnt < FW) bits[en_cnt] = cfg_i;
                en_cnt++;
            end
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_cyc = n;
                    if (sb.size() > 0) check("readback", frame_o, sb.pop_front());
                    else check("sb_empty_at_done", FW'(sb.size()), FW'(1));
                    check("done_busy", FW'(busy), FW'(1'b1));
                    check("done_cfg_en", FW'({cfg_en, cfg_i}), FW'(2'b00));
                end
            end
            if (done_cnt > 0 && n >= done_cyc + tail) break;
        end
        check("done_cycle", FW'(done_cyc), FW'(FW + 1));
        check("cfg_en_cycles", FW'(en_cnt), FW'(FW));
        check("done_pulses", FW'(done_cnt), FW'(1));
        check("serial_bits", bits, rd ? exp_o : f);
        check("chain", chain, exp_chain);
    endtask

    initial begin
        int d1, d2, nd;
        logic quiet;
        logic [FW-1:0] f4, f5, f6, f7;
        vecs[0].frame = {2'b11, 32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D, 32'h0BADC0DE};
        vecs[0].exp_o = RESET_CHAIN;
        vecs[1].frame = '0;
        vecs[1].exp_o = vecs[0].frame;
        vecs[2].frame = {2'b10, {4{32'hA5A55A5A}}};
        vecs[2].exp_o = '0;
        vecs[3].frame = '1;
        vecs[3].exp_o = vecs[2].frame;
        f4 = {2'b01, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210};
        f5 = {2'b10, 32'h0F0F0F0F, 32'h33333333, 32'h80000001, 32'h00FF00FF};
        f6 = {2'b11, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        f7 = {2'b01, 32'hC0FFEE00, 32'h0000BEEF, 32'h13579BDF, 32'h2468ACE0};

        rst_n = 1'b0; start = 1'b0; frame_i = '0; rd_only_v = 1'b0;
        #12;
        check("reset_outputs", FW'({busy, done, cfg_en, cfg_i}), FW'(4'b0000));
        check("reset_frame_o", frame_o, '0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) run_frame(vecs[i].frame, 1'b0, vecs[i].exp_o, 0);

        // start pulsed mid-shift must be dropped, not queued
        run_frame(f4, 1'b0, vecs[3].frame, 50);

`ifdef CFG_LOADER_RESTORE_EN
        run_frame('0, 1'b1, f4, 0);
        rd_only_v = 1'b0;
`endif

        // start held high: back-to-back transfers at FRAME_W+1+IDLE_GAP spacing
        @(negedge clk);
        frame_i = f5; start = 1'b1;
        sb.push_back(f4);
        sb.push_back(f5);
        d1 = 0; d2 = 0; nd = 0;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (done) begin
                nd++;
                if (sb.size() > 0) check("held_readback", frame_o, sb.pop_front());
                if (nd == 1) d1 = n;
                else begin
                    d2 = n;
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        check("held_done_count", FW'(nd), FW'(2));
        check("held_period", FW'(d2 - d1), FW'(FW + 2));
        check("held_chain", chain, f5);

        // reset asserted mid-shift: outputs clear without a clock edge, no done follows
        @(negedge clk);
        frame_i = f6; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (60) @(negedge clk);
        check("pre_reset_shift", FW'({busy, cfg_en}), FW'(2'b11));
        rst_n = 1'b0;
        #1;
        check("midrun_reset_ctl", FW'({busy, done, cfg_en, cfg_i}), FW'(4'b0000));
        check("midrun_reset_frame_o", frame_o, '0);
        quiet = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done || cfg_en || busy) quiet = 1'b0;
        end
        check("reset_quiet", FW'(quiet), FW'(1'b1));
        rst_n = 1'b1;

        run_frame(f7, 1'b0, RESET_CHAIN, 0);

        check("sb_drained", FW'(sb.size()), FW'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
